duty_preset_ram: RTL and testbench

Parametrised preset memory for servo/PWM duty positions. It captures the live multi-channel duty vector into one of DEPTH slots, recalls a slot and holds it on the outputs, and auto-plays all valid slots in sequence with a programmable dwell. It sits between the duty-generation logic (Duty_In) and the PWM drivers (DC_Out). Buttons and switches are raw board inputs; the block synchronises them and acts on rising edges internally.

---
 rtl/duty_preset_pkg.sv | 16 +
 rtl/btn_sync_edge.sv | 30 +++
 rtl/duty_preset_ram.sv | 142 ++++++++++++++
 tb/tb_duty_preset_ram.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/duty_preset_pkg.sv
// Shared mode encodings and default geometry for the duty preset memory.
// Imported by the top and by anything that decodes Mode.
package duty_preset_pkg;

   typedef enum logic [1:0] {
      MODE_LIVE = 2'd0,
      MODE_HOLD = 2'd1,
      MODE_PLAY = 2'd2
   } mode_e;

   localparam int NCH_DEF   = 2;
   localparam int DW_DEF    = 6;
   localparam int DEPTH_DEF = 8;
   localparam int DWELL_DEF = 50_000_000;

endpackage

// File: rtl/btn_sync_edge.sv
// 2-FF synchroniser plus edge register for one raw board input; level valid 2 edges after input,
// rise is a single-cycle pulse on the same cycle; no backpressure.
module btn_sync_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_in,
   output logic o_level,
   output logic o_rise
);

   logic r_s1;
   logic r_s2;
   logic r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_s1   <= i_in;
         r_s2   <= r_s1;
         r_prev <= r_s2;
      end
   end

   assign o_level = r_s2;
   assign o_rise  = r_s2 & ~r_prev;

endmodule

// File: rtl/duty_preset_ram.sv
// Duty-vector preset store with LIVE/HOLD/PLAY modes; actions land on the 3rd edge after a raw input rises,
// LIVE pass-through is 1 cycle; no backpressure (inputs are sampled every cycle).
module duty_preset_ram
   import duty_preset_pkg::*;
#(
   parameter int NCH   = NCH_DEF,
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int DWELL = DWELL_DEF
) (
   input  logic                       sysclk,
   input  logic                       Reset_Sw,
   input  logic                       Storage_Sw,
   input  logic                       Play_Sw,
   input  logic                       Bt_Up,
   input  logic                       Bt_Down,
   input  logic                       Bt_Left,
   input  logic                       Bt_Right,
   input  logic [NCH*DW-1:0]          Duty_In,
   output logic [NCH*DW-1:0]          DC_Out,
   output logic [$clog2(DEPTH)-1:0]   Slot_Idx,
   output logic                       Slot_Valid,
   output logic [1:0]                 Mode
);

   localparam int VW = NCH * DW;
   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DWELL);
   localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

   logic w_up, w_dn, w_left, w_right, w_store, w_play;
   logic w_up_lvl, w_dn_lvl, w_left_lvl, w_right_lvl, w_store_rise, w_play_rise;
   logic w_unused;

   btn_sync_edge u_up    (.i_clk(sysclk), .i_rst_n(Reset_Sw), .i_in(Bt_Up),      .o_level(w_up_lvl),    .o_rise(w_up));
   btn_sync_edge u_dn    (.i_clk(sysclk), .i_rst_n(Reset_Sw), .i_in(Bt_Down),    .o_level(w_dn_lvl),    .o_rise(w_dn));
   btn_sync_edge u_left  (.i_clk(sysclk), .i_rst_n(Reset_Sw), .i_in(Bt_Left),    .o_level(w_left_lvl),  .o_rise(w_left));
   btn_sync_edge u_right (.i_clk(sysclk), .i_rst_n(Reset_Sw), .i_in(Bt_Right),   .o_level(w_right_lvl), .o_rise(w_right));
   btn_sync_edge u_store (.i_clk(sysclk), .i_rst_n(Reset_Sw), .i_in(Storage_Sw), .o_level(w_store),     .o_rise(w_store_rise));
   btn_sync_edge u_play  (.i_clk(sysclk), .i_rst_n(Reset_Sw), .i_in(Play_Sw),    .o_level(w_play),      .o_rise(w_play_rise));

   assign w_unused = ^{w_up_lvl, w_dn_lvl, w_left_lvl, w_right_lvl, w_store_rise, w_play_rise};

   mode_e            r_mode;
   logic [IW-1:0]    r_idx;
   logic [DEPTH-1:0] r_valid;
   logic [VW-1:0]    r_dc;
   logic [CW-1:0]    r_cnt;
   logic [VW-1:0]    r_mem [DEPTH];

   // Rotate-and-priority-encode: lowest offset wins, offset DEPTH wraps back onto r_idx itself.
   logic [IW-1:0] w_first, w_next;
   logic          w_any;
   always_comb begin
      logic [IW-1:0] j0, j1;
      w_first = r_idx;
      w_next  = r_idx;
      w_any   = |r_valid;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         j0 = r_idx + IW'(i);
         j1 = r_idx + IW'(i + 1);
         if (r_valid[j0]) w_first = j0;
         if (r_valid[j1]) w_next  = j1;
      end
   end

   logic          w_step;
   logic [IW-1:0] w_new_idx;
   logic          w_recall;
   logic          w_wr;

   assign w_step    = w_up ^ w_dn;
   assign w_new_idx = w_up ? r_idx + IW'(1) : r_idx - IW'(1);
   assign w_recall  = w_right && !w_left && r_valid[r_idx];
   assign w_wr      = !w_play && (r_mode == MODE_LIVE) && w_left && w_store;

   always_ff @(posedge sysclk) begin
      if (w_wr) r_mem[r_idx] <= Duty_In;
   end

   always_ff @(posedge sysclk or negedge Reset_Sw) begin
      if (!Reset_Sw) begin
         r_mode  <= MODE_LIVE;
         r_idx   <= '0;
         r_valid <= '0;
         r_dc    <= '0;
         r_cnt   <= '0;
      end else if (w_play) begin
         if (r_mode != MODE_PLAY) begin
            r_mode <= MODE_PLAY;
            r_cnt  <= RELOAD;
            if (w_any) begin
               r_idx <= w_first;
               r_dc  <= r_mem[w_first];
            end else begin
               r_dc  <= Duty_In;
            end
         end else if (!w_any) begin
            r_dc <= Duty_In;
         end else if (r_cnt == '0) begin
            r_idx <= w_next;
            r_dc  <= r_mem[w_next];
            r_cnt <= RELOAD;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end else begin
         case (r_mode)
            MODE_LIVE: begin
               r_dc <= Duty_In;
               if (w_left) begin
                  r_valid[r_idx] <= w_store;
               end else if (w_recall) begin
                  r_mode <= MODE_HOLD;
                  r_dc   <= r_mem[r_idx];
               end
               // A recall pins the slot it read; stepping waits for the next press.
               if (w_step && !w_recall) r_idx <= w_new_idx;
            end
            MODE_HOLD: begin
               if (w_right) begin
                  r_mode <= MODE_LIVE;
                  r_dc   <= Duty_In;
               end else if (w_step) begin
                  r_idx <= w_new_idx;
                  if (r_valid[w_new_idx]) r_dc <= r_mem[w_new_idx];
               end
            end
            default: begin
               r_mode <= MODE_LIVE;
               r_dc   <= Duty_In;
            end
         endcase
      end
   end

   assign DC_Out     = r_dc;
   assign Slot_Idx   = r_idx;
   assign Slot_Valid = r_valid[r_idx];
   assign Mode       = r_mode;

endmodule

// File: tb/tb_duty_preset_ram.sv
// Directed, table-driven bench for duty_preset_ram with NCH=2, DW=6, DEPTH=4, DWELL=10.
module tb_duty_preset_ram;

   localparam int NCH = 2, DW = 6, DEPTH = 4, DWELL = 10;
   localparam int OP_NONE = 0, OP_UP = 1, OP_DN = 2, OP_LEFT = 3, OP_RIGHT = 4, OP_UPDN = 5, OP_HOLDL = 6;

   logic             sysclk = 1'b0;
   logic             Reset_Sw = 1'b0;
   logic             Storage_Sw = 1'b0, Play_Sw = 1'b0;
   logic             Bt_Up = 1'b0, Bt_Down = 1'b0, Bt_Left = 1'b0, Bt_Right = 1'b0;
   logic [11:0]      Duty_In = '0;
   logic [11:0]      DC_Out;
   logic [1:0]       Slot_Idx;
   logic             Slot_Valid;
   logic [1:0]       Mode;

   int n_chk = 0;
   int n_err = 0;

   duty_preset_ram #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .DWELL(DWELL)) dut (
      .sysclk(sysclk), .Reset_Sw(Reset_Sw), .Storage_Sw(Storage_Sw), .Play_Sw(Play_Sw),
      .Bt_Up(Bt_Up), .Bt_Down(Bt_Down), .Bt_Left(Bt_Left), .Bt_Right(Bt_Right),
      .Duty_In(Duty_In), .DC_Out(DC_Out), .Slot_Idx(Slot_Idx), .Slot_Valid(Slot_Valid), .Mode(Mode)
   );

   always #5 sysclk = ~sysclk;

   typedef struct {
      int          op;
      logic        stor;
      logic [11:0] duty;
      logic [1:0]  idx;
      logic        vld;
      logic [1:0]  mode;
      logic [11:0] dc;
      string       nm;
   } vec_t;

   function automatic logic [11:0] pk(input int c0, input int c1);
      return {6'(c1), 6'(c0)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_btn(input int op, input logic v);
      case (op)
         OP_UP:            Bt_Up = v;
         OP_DN:            Bt_Down = v;
         OP_LEFT, OP_HOLDL: Bt_Left = v;
         OP_RIGHT:         Bt_Right = v;
         OP_UPDN:          begin Bt_Up = v; Bt_Down = v; end
         default:          ;
      endcase
   endtask

   task automatic pulse(input int op);
      @(posedge sysclk); #1;
      set_btn(op, 1'b1);
      repeat (4) @(posedge sysclk);
      #1 set_btn(op, 1'b0);
      repeat (4) @(posedge sysclk);
   endtask

   task automatic apply(input vec_t v);
      @(posedge sysclk); #1;
      Storage_Sw = v.stor;
      Duty_In    = v.duty;
      repeat (4) @(posedge sysclk);
      #1 set_btn(v.op, 1'b1);
      // Held store: input changes mid-hold must not be captured a second time.
      if (v.op == OP_HOLDL) begin
         repeat (10) @(posedge sysclk);
         #1 Duty_In = pk(7, 7);
         repeat (90) @(posedge sysclk);
      end else begin
         repeat (4) @(posedge sysclk);
      end
      #1 set_btn(v.op, 1'b0);
      repeat (4) @(posedge sysclk);
      @(negedge sysclk);
      chk({v.nm, "_idx"},  32'(Slot_Idx),   32'(v.idx));
      chk({v.nm, "_vld"},  32'(Slot_Valid), 32'(v.vld));
      chk({v.nm, "_mode"}, 32'(Mode),       32'(v.mode));
      chk({v.nm, "_dc"},   32'(DC_Out),     32'(v.dc));
   endtask

   vec_t        tv [18];
   logic [11:0] live_tv [4];

   initial begin
      live_tv[0] = pk(30, 32); live_tv[1] = pk(1, 63); live_tv[2] = pk(0, 0); live_tv[3] = pk(63, 63);
      tv[0]  = '{OP_LEFT,  1'b1, pk(30, 32), 2'd0, 1'b1, 2'd0, pk(30, 32), "store0"};
      tv[1]  = '{OP_UP,    1'b1, pk(30, 32), 2'd1, 1'b0, 2'd0, pk(30, 32), "up1"};
      tv[2]  = '{OP_HOLDL, 1'b1, pk(50, 52), 2'd1, 1'b1, 2'd0, pk(7, 7),   "heldstore1"};
      tv[3]  = '{OP_DN,    1'b0, pk(10, 10), 2'd0, 1'b1, 2'd0, pk(10, 10), "down0"};
      tv[4]  = '{OP_RIGHT, 1'b0, pk(10, 10), 2'd0, 1'b1, 2'd1, pk(30, 32), "recall0"};
      tv[5]  = '{OP_UP,    1'b0, pk(10, 10), 2'd1, 1'b1, 2'd1, pk(50, 52), "hold_up1"};
      tv[6]  = '{OP_UP,    1'b0, pk(10, 10), 2'd2, 1'b0, 2'd1, pk(50, 52), "hold_empty2"};
      tv[7]  = '{OP_RIGHT, 1'b0, pk(10, 10), 2'd2, 1'b0, 2'd0, pk(10, 10), "back_live"};
      tv[8]  = '{OP_UP,    1'b0, pk(10, 10), 2'd3, 1'b0, 2'd0, pk(10, 10), "up3"};
      tv[9]  = '{OP_UP,    1'b0, pk(10, 10), 2'd0, 1'b1, 2'd0, pk(10, 10), "wrap_up0"};
      tv[10] = '{OP_DN,    1'b0, pk(10, 10), 2'd3, 1'b0, 2'd0, pk(10, 10), "wrap_dn3"};
      tv[11] = '{OP_UPDN,  1'b0, pk(10, 10), 2'd3, 1'b0, 2'd0, pk(10, 10), "updn"};
      tv[12] = '{OP_RIGHT, 1'b0, pk(10, 10), 2'd3, 1'b0, 2'd0, pk(10, 10), "recall_empty"};
      tv[13] = '{OP_UP,    1'b0, pk(10, 10), 2'd0, 1'b1, 2'd0, pk(10, 10), "to0"};
      tv[14] = '{OP_UP,    1'b0, pk(10, 10), 2'd1, 1'b1, 2'd0, pk(10, 10), "to1"};
      tv[15] = '{OP_LEFT,  1'b0, pk(10, 10), 2'd1, 1'b0, 2'd0, pk(10, 10), "clear1"};
      tv[16] = '{OP_LEFT,  1'b1, pk(50, 52), 2'd1, 1'b1, 2'd0, pk(50, 52), "restore1"};
      tv[17] = '{OP_UP,    1'b1, pk(21, 22), 2'd2, 1'b0, 2'd0, pk(21, 22), "to2"};

      // Reset held: outputs at their reset values regardless of Duty_In.
      Duty_In = pk(30, 32);
      repeat (3) @(posedge sysclk);
      @(negedge sysclk);
      chk("rst_dc", 32'(DC_Out), 32'd0);
      chk("rst_idx", 32'(Slot_Idx), 32'd0);
      chk("rst_mode", 32'(Mode), 32'd0);
      chk("rst_vld", 32'(Slot_Valid), 32'd0);
      @(posedge sysclk); #1 Reset_Sw = 1'b1;

      for (int i = 0; i < 4; i++) begin
         @(posedge sysclk); #1 Duty_In = live_tv[i];
         @(posedge sysclk); #1;
         chk("live_pass", 32'(DC_Out), 32'(live_tv[i]));
      end

      for (int i = 0; i < 18; i++) apply(tv[i]);

      // Store then recall on the very next cycle returns the freshly written data.
      @(posedge sysclk); #1 Bt_Left = 1'b1;
      @(posedge sysclk); #1 Bt_Right = 1'b1;
      repeat (4) @(posedge sysclk);
      #1 begin Bt_Left = 1'b0; Bt_Right = 1'b0; end
      repeat (4) @(posedge sysclk);
      @(negedge sysclk);
      chk("wr_recall_mode", 32'(Mode), 32'd1);
      chk("wr_recall_dc", 32'(DC_Out), 32'(pk(21, 22)));
      chk("wr_recall_vld", 32'(Slot_Valid), 32'd1);
      pulse(OP_RIGHT);
      @(negedge sysclk);
      chk("wr_recall_exit", 32'(Mode), 32'd0);

      // Left+Right together: clear wins, recall is dropped.
      @(posedge sysclk); #1 Storage_Sw = 1'b0;
      repeat (4) @(posedge sysclk);
      #1 begin Bt_Left = 1'b1; Bt_Right = 1'b1; end
      repeat (4) @(posedge sysclk);
      #1 begin Bt_Left = 1'b0; Bt_Right = 1'b0; Storage_Sw = 1'b1; Duty_In = pk(10, 10); end
      repeat (4) @(posedge sysclk);
      @(negedge sysclk);
      chk("lr_mode", 32'(Mode), 32'd0);
      chk("lr_vld", 32'(Slot_Valid), 32'd0);

      // Playback over slots 0/1 from idx 2; buttons poked mid-play must do nothing.
      @(posedge sysclk); #1 Play_Sw = 1'b1;
      for (int c = 1; c <= 45; c++) begin
         int k;
         @(posedge sysclk); #1;
         if (c == 15) Bt_Up = 1'b1;
         if (c == 20) Bt_Up = 1'b0;
         if (c == 25) Bt_Left = 1'b1;
         if (c == 30) Bt_Left = 1'b0;
         @(negedge sysclk);
         if (c < 3) begin
            chk("play_pre_mode", 32'(Mode), 32'd0);
            chk("play_pre_idx", 32'(Slot_Idx), 32'd2);
            chk("play_pre_dc", 32'(DC_Out), 32'(pk(10, 10)));
         end else begin
            k = ((c - 3) / DWELL) % 2;
            chk("play_mode", 32'(Mode), 32'd2);
            chk("play_idx", 32'(Slot_Idx), 32'(k));
            chk("play_dc", 32'(DC_Out), (k == 0) ? 32'(pk(30, 32)) : 32'(pk(50, 52)));
         end
      end
      #1 Play_Sw = 1'b0;
      repeat (5) @(posedge sysclk);
      @(negedge sysclk);
      chk("play_exit_mode", 32'(Mode), 32'd0);
      chk("play_exit_dc", 32'(DC_Out), 32'(pk(10, 10)));

      // Reset pulled mid-play takes effect without a clock edge.
      @(posedge sysclk); #1 Play_Sw = 1'b1;
      repeat (20) @(posedge sysclk);
      @(negedge sysclk);
      chk("play2_mode", 32'(Mode), 32'd2);
      chk("play2_vld", 32'(Slot_Valid), 32'd1);
      #1 begin Reset_Sw = 1'b0; Play_Sw = 1'b0; end
      #1;
      chk("async_rst_dc", 32'(DC_Out), 32'd0);
      chk("async_rst_mode", 32'(Mode), 32'd0);
      chk("async_rst_vld", 32'(Slot_Valid), 32'd0);
      repeat (3) @(posedge sysclk);
      #1 Reset_Sw = 1'b1;

      // No valid slots: PLAY passes Duty_In straight through.
      @(posedge sysclk); #1 Play_Sw = 1'b1;
      repeat (4) @(posedge sysclk);
      for (int i = 0; i < 4; i++) begin
         #1 Duty_In = live_tv[i];
         @(posedge sysclk); #1;
         chk("play_empty_dc", 32'(DC_Out), 32'(live_tv[i]));
         chk("play_empty_mode", 32'(Mode), 32'd2);
      end
      #1 Play_Sw = 1'b0;
      repeat (5) @(posedge sysclk);
      pulse(OP_RIGHT);
      @(negedge sysclk);
      chk("post_rst_recall_mode", 32'(Mode), 32'd0);
      chk("post_rst_idx", 32'(Slot_Idx), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
